pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage core. It drives the enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken-branch squashes and data-memory wait states, and runs a drain-then-halt sequence for debug/halt requests. It also keeps stall and flush event counters.

---
 rtl/pipe_ctrl_pkg.sv | 32 +++
 rtl/pipe_ctrl_hazard_detect.sv | 23 ++
 rtl/pipe_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the five-stage pipeline sequencing controller.
package pipe_ctrl_pkg;

  localparam int XLEN        = 32;
  localparam int RFIDX_WIDTH = 5;
  localparam int DCNT_W      = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } pc_state_e;

  // Per-cycle pipeline register controls; a flush loads a bubble (control fields 0).
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_flush;
  } pipe_ctrl_t;

  // Free-running pipeline: every register loads, nothing squashed.
  localparam pipe_ctrl_t CTRL_PASS   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  // Frozen pipeline: nothing moves, nothing squashed.
  localparam pipe_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  // Data-memory wait: upstream frozen, bubble written into MEM/WB.
  localparam pipe_ctrl_t CTRL_MEMWAIT = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard comparison between the ID instruction and a load sitting in EX.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [RFIDX_WIDTH-1:0] id_rs1_index,
  input  logic [RFIDX_WIDTH-1:0] id_rs2_index,
  input  logic                   id_rs1_used,
  input  logic                   id_rs2_used,
  input  logic [RFIDX_WIDTH-1:0] ex_rd_index,
  input  logic                   ex_mem_read,
  output logic                   load_use
);

  logic rs1_hit, rs2_hit;

  // x0 is never a real producer, so a load targeting it can't create a hazard.
  always_comb begin
    rs1_hit  = id_rs1_used && (id_rs1_index == ex_rd_index);
    rs2_hit  = id_rs2_used && (id_rs2_index == ex_rd_index);
    load_use = ex_mem_read && (ex_rd_index != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: hazard stalls, branch squashes, memory waits,
// drain-then-halt sequencing and stall/flush event counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [RFIDX_WIDTH-1:0] id_rs1_index,
  input  logic [RFIDX_WIDTH-1:0] id_rs2_index,
  input  logic                   id_rs1_used,
  input  logic                   id_rs2_used,
  input  logic [RFIDX_WIDTH-1:0] ex_rd_index,
  input  logic                   ex_mem_read,
  input  logic                   ex_take,
  input  logic                   dmem_req,
  input  logic                   dmem_ack,
  input  logic                   halt_req,
  input  logic                   cnt_clr,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   id_ex_en,
  output logic                   ex_mem_en,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   mem_wb_flush,
  output logic                   halted,
  output logic [XLEN-1:0]        stall_cycles,
  output logic [XLEN-1:0]        flush_count
);

  localparam logic [DCNT_W-1:0] DRAIN_INIT = DCNT_W'(DRAIN_CYCLES);

  pc_state_e         state;
  logic [DCNT_W-1:0] drain_cnt;
  logic              mem_stall;
  logic              load_use;
  logic              take_evt;
  logic              stall_evt;
  pipe_ctrl_t        ctrl;

  hazard_detect u_hazard (
    .id_rs1_index (id_rs1_index),
    .id_rs2_index (id_rs2_index),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .ex_rd_index  (ex_rd_index),
    .ex_mem_read  (ex_mem_read),
    .load_use     (load_use)
  );

  assign mem_stall = dmem_req && !dmem_ack;

  // Output mux: memory wait overrides everything, then halted freeze, then branch > load-use > drain.
  always_comb begin
    ctrl = CTRL_PASS;
    if (mem_stall) begin
      ctrl = CTRL_MEMWAIT;
    end else if (state == ST_HALTED) begin
      ctrl = CTRL_FREEZE;
    end else if (ex_take) begin
      // PC stays enabled so the redirect target is captured, even while draining.
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end else if (load_use) begin
      // Hold ID in place (no flush into IF/ID) and slip one bubble into EX.
      ctrl.pc_en       = 1'b0;
      ctrl.if_id_en    = 1'b0;
      ctrl.id_ex_flush = 1'b1;
    end else if (state == ST_DRAIN) begin
      ctrl.pc_en       = 1'b0;
      ctrl.if_id_flush = 1'b1;
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign if_id_en     = ctrl.if_id_en;
  assign id_ex_en     = ctrl.id_ex_en;
  assign ex_mem_en    = ctrl.ex_mem_en;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign mem_wb_flush = ctrl.mem_wb_flush;

  assign take_evt  = ex_take && !mem_stall && (state != ST_HALTED);
  assign stall_evt = !ctrl.pc_en && (state != ST_HALTED);

  // Halt sequencing FSM; a memory wait freezes state, drain count and halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      halted    <= 1'b0;
    end else if (!mem_stall) begin
      case (state)
        ST_RUN: begin
          if (halt_req) begin
            state     <= ST_DRAIN;
            drain_cnt <= DRAIN_INIT;
          end
        end
        ST_DRAIN: begin
          if (!halt_req) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
          end else if (drain_cnt <= DCNT_W'(1)) begin
            // Last drain cycle: counter reaches zero and the pipe is empty.
            state     <= ST_HALTED;
            drain_cnt <= '0;
            halted    <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DCNT_W'(1);
          end
        end
        ST_HALTED: begin
          if (!halt_req) begin
            state  <= ST_RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state     <= ST_RUN;
          drain_cnt <= '0;
          halted    <= 1'b0;
        end
      endcase
    end
  end

  // Event counters; clear wins over a same-cycle increment, both wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else if (cnt_clr) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_evt) stall_cycles <= stall_cycles + XLEN'(1);
      if (take_evt)  flush_count  <= flush_count + XLEN'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed table-driven bench for pipe_ctrl plus hand-written halt/reset sequences.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [RFIDX_WIDTH-1:0] id_rs1_index, id_rs2_index, ex_rd_index;
  logic                   id_rs1_used, id_rs2_used, ex_mem_read, ex_take;
  logic                   dmem_req, dmem_ack, halt_req, cnt_clr;
  logic                   pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic                   if_id_flush, id_ex_flush, mem_wb_flush, halted;
  logic [XLEN-1:0]        stall_cycles, flush_count;

  int checks = 0;
  int failures = 0;

  pipe_ctrl #(.DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_index(id_rs1_index), .id_rs2_index(id_rs2_index),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd_index(ex_rd_index), .ex_mem_read(ex_mem_read), .ex_take(ex_take),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack), .halt_req(halt_req), .cnt_clr(cnt_clr),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
    .halted(halted), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush}
  typedef struct {
    string    name;
    logic [4:0] rs1, rs2, rd;
    logic     u1, u2, mr, take, req, ack;
    logic [6:0] exp;
  } vec_t;

  function automatic logic [6:0] ctl();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    id_rs1_index = 0; id_rs2_index = 0; ex_rd_index = 0;
    id_rs1_used = 0; id_rs2_used = 0; ex_mem_read = 0; ex_take = 0;
    dmem_req = 0; dmem_ack = 0; cnt_clr = 0;
  endtask

  task automatic clear_counters();
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{"idle",          0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1111000};
    vecs[1]  = '{"lu_rs1_x5",     5, 0, 5, 1, 0, 1, 0, 0, 0, 7'b0011010};
    vecs[2]  = '{"lu_rd_x0",      0, 0, 0, 1, 0, 1, 0, 0, 0, 7'b1111000};
    vecs[3]  = '{"lu_rs2_x5",     3, 5, 5, 1, 1, 1, 0, 0, 0, 7'b0011010};
    vecs[4]  = '{"rs2_unused",    3, 5, 5, 1, 0, 1, 0, 0, 0, 7'b1111000};
    vecs[5]  = '{"not_load",      5, 0, 5, 1, 0, 0, 0, 0, 0, 7'b1111000};
    vecs[6]  = '{"take_over_lu",  5, 0, 5, 1, 0, 1, 1, 0, 0, 7'b1111110};
    vecs[7]  = '{"take",          0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b1111110};
    vecs[8]  = '{"memwait_take",  0, 0, 0, 0, 0, 0, 1, 1, 0, 7'b0000001};
    vecs[9]  = '{"ack_lu",        7, 0, 7, 1, 0, 1, 0, 1, 1, 7'b0011010};
    vecs[10] = '{"ack_take",      0, 0, 0, 0, 0, 0, 1, 1, 1, 7'b1111110};

    idle(); halt_req = 0; rst_n = 0;
    #12;
    // Reset state
    chk("rst_ctrl", ctl(), 7'b1111000);
    chk("rst_halted", halted, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_flush", flush_count, 0);
    rst_n = 1; tick();

    // Table: one cycle per vector in RUN; counters tallied from expected controls.
    begin
      int exp_stall = 0, exp_flush = 0;
      for (int i = 0; i < 11; i++) begin
        id_rs1_index = vecs[i].rs1; id_rs2_index = vecs[i].rs2; ex_rd_index = vecs[i].rd;
        id_rs1_used = vecs[i].u1; id_rs2_used = vecs[i].u2; ex_mem_read = vecs[i].mr;
        ex_take = vecs[i].take; dmem_req = vecs[i].req; dmem_ack = vecs[i].ack;
        #2;
        chk(vecs[i].name, ctl(), vecs[i].exp);
        if (!vecs[i].exp[6]) exp_stall++;
        if (vecs[i].exp[2]) exp_flush++;
        tick();
      end
      idle();
      chk("tbl_stall_cnt", stall_cycles, exp_stall);
      chk("tbl_flush_cnt", flush_count, exp_flush);
    end

    // Memory wait of 4 cycles with a taken branch held throughout.
    clear_counters();
    ex_take = 1; dmem_req = 1; dmem_ack = 0;
    for (int c = 0; c < 4; c++) begin
      #2; chk($sformatf("mw_ctrl_%0d", c), ctl(), 7'b0000001);
      tick();
    end
    dmem_ack = 1; #2;
    chk("mw_ack_ctrl", ctl(), 7'b1111110);
    tick(); idle();
    chk("mw_stall_cnt", stall_cycles, 4);
    chk("mw_flush_cnt", flush_count, 1);

    // Halt held: DRAIN for 3 cycles, then halted.
    clear_counters();
    halt_req = 1; #2;
    chk("halt_t0_ctrl", ctl(), 7'b1111000);
    tick();
    for (int c = 1; c <= 3; c++) begin
      #2;
      chk($sformatf("drain_%0d_ctrl", c), ctl(), 7'b0111100);
      chk($sformatf("drain_%0d_halted", c), halted, 0);
      tick();
    end
    chk("halted_on", halted, 1);
    chk("halted_ctrl", ctl(), 7'b0000000);
    tick(); tick();
    chk("halted_hold", halted, 1);
    chk("halt_stall_cnt", stall_cycles, 3);
    halt_req = 0; #2;
    chk("halted_until_edge", halted, 1);
    tick();
    chk("resume_halted", halted, 0);
    chk("resume_ctrl", ctl(), 7'b1111000);

    // Memory wait during drain stretches it by one cycle.
    halt_req = 1; tick();
    tick();                              // drain cycle 1
    dmem_req = 1; tick();                // stalled, counter held
    dmem_req = 0; tick();                // drain cycle 2
    chk("drain_ms_not_yet", halted, 0);
    tick();                              // drain cycle 3
    chk("drain_ms_halted", halted, 1);
    halt_req = 0; tick();
    chk("drain_ms_resume", halted, 0);

    // One-cycle halt pulse: one DRAIN cycle, then RUN, never halted.
    halt_req = 1; tick(); halt_req = 0; #2;
    chk("pulse_drain_ctrl", ctl(), 7'b0111100);
    tick(); #2;
    chk("pulse_run_ctrl", ctl(), 7'b1111000);
    begin
      logic seen = 0;
      for (int c = 0; c < 5; c++) begin
        if (halted) seen = 1;
        tick();
      end
      chk("pulse_never_halted", seen, 0);
    end

    // Async reset mid-drain with non-zero counters.
    clear_counters();
    ex_take = 1;
    for (int c = 0; c < 7; c++) tick();
    ex_take = 0;
    chk("pre_rst_flush", flush_count, 7);
    halt_req = 1; tick(); tick();
    #2; rst_n = 0; #1;
    chk("rst_mid_halted", halted, 0);
    chk("rst_mid_stall", stall_cycles, 0);
    chk("rst_mid_flush", flush_count, 0);
    chk("rst_mid_ctrl", ctl(), 7'b1111000);
    halt_req = 0;
    tick(); rst_n = 1; tick();

    // Clear beats a same-cycle flush increment.
    ex_take = 1; tick(); tick();
    chk("pre_clr_flush", flush_count, 2);
    cnt_clr = 1; tick(); idle();
    chk("clr_vs_take", flush_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
